simd_seq: RTL and testbench

Command sequencer for the 8-lane `simd_arr` datapath (add / sub / 3x3 matmul). It buffers operation commands from the host-side issue logic and fetches both 8×UNIT_SIZE operands from the shared operand scratchpad. It then drives the combinational array, captures the result and writes it back, one command at a time with strict in-order completion.

---
 rtl/simd_seq.sv | 171 +++++++++++++++++
 tb/tb_simd_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_seq.sv
// In-order command sequencer for the 8-lane simd_arr datapath: queues commands,
// fetches both operands from the scratchpad, runs the array and writes the result back.
module simd_seq #(
    parameter int UNIT_SIZE = 32,
    parameter int ADDR_W    = 8,
    parameter int Q_DEPTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [1:0]             i_cmd_op,
    input  logic [ADDR_W-1:0]      i_cmd_src1,
    input  logic [ADDR_W-1:0]      i_cmd_src2,
    input  logic [ADDR_W-1:0]      i_cmd_dst,
    output logic                   o_mem_ren,
    output logic [ADDR_W-1:0]      o_mem_raddr,
    input  logic [8*UNIT_SIZE-1:0] i_mem_rdata,
    output logic                   o_mem_wen,
    output logic [ADDR_W-1:0]      o_mem_waddr,
    output logic [8*UNIT_SIZE-1:0] o_mem_wdata,
    output logic [1:0]             o_arr_opcode,
    output logic [8*UNIT_SIZE-1:0] o_arr_in1,
    output logic [8*UNIT_SIZE-1:0] o_arr_in2,
    input  logic [8*UNIT_SIZE-1:0] i_arr_res,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_busy
);
    localparam int VEC_W = 8 * UNIT_SIZE;
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(Q_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_RD2  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;

    localparam logic [1:0] OP_MATMUL  = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] src1;
        logic [ADDR_W-1:0] src2;
        logic [ADDR_W-1:0] dst;
    } cmd_t;

    cmd_t              fifo_mem [Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              fifo_empty, fifo_full, push, pop;
    cmd_t              fifo_head;

    logic [2:0]        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [VEC_W-1:0]  op1_q, op1_d, op2_q, op2_d, res_q, res_d;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FULL_CNT);
    assign o_cmd_ready = !fifo_full && !i_rst;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign fifo_head   = fifo_mem[rd_ptr_q];

    assign o_arr_in1    = op1_q;
    assign o_arr_in2    = op2_q;
    assign o_arr_opcode = cmd_q.op;
    assign o_busy       = (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        res_d       = res_q;
        pop         = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_raddr = '0;
        o_mem_wen   = 1'b0;
        o_mem_waddr = '0;
        o_mem_wdata = '0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_head;
                    state_d = S_RD1;
                end
            end
            S_RD1: begin
                if (cmd_q.op == OP_ILLEGAL) begin
                    o_err   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    o_mem_ren   = 1'b1;
                    o_mem_raddr = cmd_q.src1;
                    state_d     = S_RD2;
                end
            end
            S_RD2: begin
                o_mem_ren   = 1'b1;
                o_mem_raddr = cmd_q.src2;
                op1_d       = i_mem_rdata;
                state_d     = S_CAP;
            end
            S_CAP: begin
                op2_d   = i_mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d = i_arr_res;
                // Matmul only produces Y2..Y0 in lanes 0..2; clear the rest.
                if (cmd_q.op == OP_MATMUL) begin
                    res_d[VEC_W-3*UNIT_SIZE-1:0] = '0;
                end
                state_d = S_WB;
            end
            S_WB: begin
                o_mem_wen   = 1'b1;
                o_mem_waddr = cmd_q.dst;
                o_mem_wdata = res_q;
                o_done      = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = fifo_head;
                    state_d = S_RD1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            res_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage has no reset; emptiness is tracked solely by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{op: i_cmd_op, src1: i_cmd_src1, src2: i_cmd_src2, dst: i_cmd_dst};
        end
    end
endmodule

// File: tb/tb_simd_seq.sv
// Bench for simd_seq: behavioural scratchpad and array, write-back scoreboard.
module tb_simd_seq;
    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_cmd_valid = 1'b0;
    logic         o_cmd_ready;
    logic [1:0]   i_cmd_op = 2'd0;
    logic [7:0]   i_cmd_src1 = 8'd0, i_cmd_src2 = 8'd0, i_cmd_dst = 8'd0;
    logic         o_mem_ren, o_mem_wen, o_done, o_err, o_busy;
    logic [7:0]   o_mem_raddr, o_mem_waddr;
    logic [255:0] i_mem_rdata = '0;
    logic [255:0] o_mem_wdata, o_arr_in1, o_arr_in2, i_arr_res;
    logic [1:0]   o_arr_opcode;

    simd_seq #(.UNIT_SIZE(32), .ADDR_W(8), .Q_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_src1(i_cmd_src1), .i_cmd_src2(i_cmd_src2), .i_cmd_dst(i_cmd_dst),
        .o_mem_ren(o_mem_ren), .o_mem_raddr(o_mem_raddr), .i_mem_rdata(i_mem_rdata),
        .o_mem_wen(o_mem_wen), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
        .o_arr_opcode(o_arr_opcode), .o_arr_in1(o_arr_in1), .o_arr_in2(o_arr_in2),
        .i_arr_res(i_arr_res), .o_done(o_done), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Array model: lanes 3..7 of a matmul carry junk so the sequencer must clear them.
    function automatic logic [255:0] arr_fn(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b);
        logic [31:0] la [8];
        logic [31:0] lb [8];
        logic [31:0] r [8];
        logic [31:0] m [3][3];
        logic [31:0] y [3];
        logic [255:0] out;
        for (int k = 0; k < 8; k++) begin
            la[k] = a[(7-k)*32 +: 32];
            lb[k] = b[(7-k)*32 +: 32];
            r[k]  = 32'd0;
        end
        case (op)
            2'd0: for (int k = 0; k < 8; k++) r[k] = la[k] + lb[k];
            2'd1: for (int k = 0; k < 8; k++) r[k] = la[k] - lb[k];
            2'd2: begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        m[i][j] = (3*i + j < 8) ? la[3*i + j] : lb[7];
                for (int i = 0; i < 3; i++)
                    y[i] = m[i][0]*lb[0] + m[i][1]*lb[1] + m[i][2]*lb[2];
                r[0] = y[2];
                r[1] = y[1];
                r[2] = y[0];
                for (int k = 3; k < 8; k++) r[k] = 32'hA5A5_0000 + 32'(k);
            end
            default: for (int k = 0; k < 8; k++) r[k] = 32'hDEAD_BEEF;
        endcase
        for (int k = 0; k < 8; k++) out[(7-k)*32 +: 32] = r[k];
        return out;
    endfunction

    assign i_arr_res = arr_fn(o_arr_opcode, o_arr_in1, o_arr_in2);

    logic [255:0] mem [256];
    logic [255:0] ref_mem [256];
    logic         pre_we = 1'b0;
    logic [7:0]   pre_addr = 8'd0;
    logic [255:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (o_mem_wen) mem[o_mem_waddr] <= o_mem_wdata;
        if (o_mem_ren) i_mem_rdata <= mem[o_mem_raddr];
    end

    typedef struct {
        int           cyc;
        logic [7:0]   addr;
        logic [255:0] data;
        logic         done;
    } wr_t;
    typedef struct {
        logic [7:0]   addr;
        logic [255:0] data;
    } exp_t;

    wr_t  obs_q [$];
    exp_t exp_q [$];
    int   ren_cyc_q [$];
    logic [7:0] ren_addr_q [$];
    int   err_cyc_q [$];
    int   stray_done = 0;
    int   hs_cyc = 0;
    bit   ready_low_seen = 1'b0;
    wr_t  mon_w;

    always @(negedge clk) begin
        if (o_mem_wen) begin
            mon_w.cyc  = cyc;
            mon_w.addr = o_mem_waddr;
            mon_w.data = o_mem_wdata;
            mon_w.done = o_done;
            obs_q.push_back(mon_w);
        end else if (o_done) begin
            stray_done++;
        end
        if (o_mem_ren) begin
            ren_cyc_q.push_back(cyc);
            ren_addr_q.push_back(o_mem_raddr);
        end
        if (o_err) err_cyc_q.push_back(cyc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [255:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] s1, input logic [7:0] s2,
                            input logic [7:0] d, input bit expect_wr);
        int guard = 0;
        exp_t e;
        i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_src1 = s1; i_cmd_src2 = s2; i_cmd_dst = d;
        while (!o_cmd_ready && guard < 100) begin
            ready_low_seen = 1'b1;
            step();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL push_timeout: ready=%0b after %0d cycles, required 1", o_cmd_ready, guard);
        end
        hs_cyc = cyc;
        if (expect_wr && op != 2'd3) begin
            e.addr = d;
            e.data = arr_fn(op, ref_mem[s1], ref_mem[s2]);
            if (op == 2'd2) e.data[159:0] = '0;
            ref_mem[d] = e.data;
            exp_q.push_back(e);
        end
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int guard = 0;
        while (obs_q.size() < n && guard < 300) begin
            step();
            guard++;
        end
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("FAIL write_timeout: writes=%0d, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic check_writes(input int n);
        wr_t w;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (obs_q.size() == 0 || exp_q.size() == 0) break;
            w = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (w.addr !== e.addr || w.data !== e.data || w.done !== 1'b1) begin
                errors++;
                $display("FAIL writeback[%0d]: addr=%0d data=%h done=%0b, required addr=%0d data=%h done=1",
                         i, w.addr, w.data, w.done, e.addr, e.data);
            end else begin
                $display("write addr=%0d data=%h cycle=%0d", w.addr, w.data, w.cyc);
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step(); step(); step();
        checks++;
        if (o_cmd_ready !== 1'b0 || o_busy !== 1'b0 || o_mem_wen !== 1'b0 || o_mem_ren !== 1'b0 ||
            o_done !== 1'b0 || o_err !== 1'b0 || o_arr_in1 !== '0 || o_arr_opcode !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%0b busy=%0b wen=%0b ren=%0b done=%0b err=%0b in1=%h opc=%0d, required all 0",
                     o_cmd_ready, o_busy, o_mem_wen, o_mem_ren, o_done, o_err, o_arr_in1, o_arr_opcode);
        end
        i_rst = 1'b0;
        step();
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: ready=%0b, required 1", o_cmd_ready);
        end
        $display("reset done, ready=%0b busy=%0b", o_cmd_ready, o_busy);
    endtask

    task automatic test_add();
        logic [255:0] a, b, want;
        int t;
        for (int k = 0; k < 8; k++) begin
            a[(7-k)*32 +: 32]    = 32'(k + 1);
            b[(7-k)*32 +: 32]    = 32'(10 * (k + 1));
            want[(7-k)*32 +: 32] = 32'(11 * (k + 1));
        end
        set_mem(8'd1, a);
        set_mem(8'd2, b);
        push_cmd(2'd0, 8'd1, 8'd2, 8'd3, 1'b1);
        t = hs_cyc;
        wait_writes(1);
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].cyc - t !== 6) begin
                errors++;
                $display("FAIL add_latency: %0d cycles, required 6", obs_q[0].cyc - t);
            end
        end
        check_writes(1);
        step();
        checks++;
        if (mem[3] !== want || stray_done !== 0) begin
            errors++;
            $display("FAIL add_result: mem[3]=%h stray_done=%0d, required %h and 0", mem[3], stray_done, want);
        end
    endtask

    task automatic test_sub();
        logic [255:0] a, b, want;
        for (int k = 0; k < 8; k++) begin
            a[(7-k)*32 +: 32]    = (k == 0) ? 32'd0 : 32'(100 + k);
            b[(7-k)*32 +: 32]    = (k == 0) ? 32'd1 : 32'(k);
            want[(7-k)*32 +: 32] = (k == 0) ? 32'hFFFF_FFFF : 32'd100;
        end
        set_mem(8'd4, a);
        set_mem(8'd5, b);
        push_cmd(2'd1, 8'd4, 8'd5, 8'd6, 1'b1);
        wait_writes(1);
        check_writes(1);
        step();
        checks++;
        if (mem[6] !== want) begin
            errors++;
            $display("FAIL sub_wrap: mem[6]=%h, required %h", mem[6], want);
        end
    endtask

    task automatic test_matmul();
        logic [255:0] a, b, want;
        a = '0; b = '0; want = '0;
        a[(7-0)*32 +: 32] = 32'd1;
        a[(7-4)*32 +: 32] = 32'd1;
        b[(7-0)*32 +: 32] = 32'd2;
        b[(7-1)*32 +: 32] = 32'd3;
        b[(7-2)*32 +: 32] = 32'd4;
        b[(7-7)*32 +: 32] = 32'd1;
        want[(7-0)*32 +: 32] = 32'd4;
        want[(7-1)*32 +: 32] = 32'd3;
        want[(7-2)*32 +: 32] = 32'd2;
        set_mem(8'd7, a);
        set_mem(8'd8, b);
        push_cmd(2'd2, 8'd7, 8'd8, 8'd9, 1'b1);
        wait_writes(1);
        check_writes(1);
        step();
        checks++;
        if (mem[9] !== want) begin
            errors++;
            $display("FAIL matmul_result: mem[9]=%h, required %h", mem[9], want);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] want;
        for (int k = 0; k < 8; k++) want[(7-k)*32 +: 32] = 32'(12 * (k + 1));
        ready_low_seen = 1'b0;
        push_cmd(2'd0, 8'd1,  8'd2,  8'd10, 1'b1);
        push_cmd(2'd0, 8'd10, 8'd1,  8'd11, 1'b1);
        push_cmd(2'd1, 8'd11, 8'd2,  8'd12, 1'b1);
        push_cmd(2'd0, 8'd3,  8'd3,  8'd13, 1'b1);
        push_cmd(2'd0, 8'd12, 8'd13, 8'd14, 1'b1);
        push_cmd(2'd0, 8'd14, 8'd1,  8'd15, 1'b1);
        wait_writes(6);
        checks++;
        if (ready_low_seen !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full: ready_low_seen=%0b, required 1", ready_low_seen);
        end
        for (int i = 0; i + 1 < 6 && i + 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i+1].cyc - obs_q[i].cyc !== 5) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: %0d cycles, required 5", i, obs_q[i+1].cyc - obs_q[i].cyc);
            end
        end
        check_writes(6);
        step();
        checks++;
        if (mem[11] !== want) begin
            errors++;
            $display("FAIL b2b_hazard: mem[11]=%h, required %h", mem[11], want);
        end
    endtask

    task automatic test_illegal();
        int t_ill;
        ren_cyc_q.delete();
        ren_addr_q.delete();
        err_cyc_q.delete();
        push_cmd(2'd3, 8'd1, 8'd2, 8'd20, 1'b1);
        t_ill = hs_cyc;
        push_cmd(2'd0, 8'd1, 8'd2, 8'd21, 1'b1);
        wait_writes(1);
        checks++;
        if (err_cyc_q.size() !== 1 || (err_cyc_q.size() > 0 && err_cyc_q[0] !== t_ill + 2)) begin
            errors++;
            $display("FAIL illegal_err: pulses=%0d first=%0d, required 1 pulse at %0d",
                     err_cyc_q.size(), (err_cyc_q.size() > 0) ? err_cyc_q[0] : -1, t_ill + 2);
        end
        checks++;
        if (ren_cyc_q.size() !== 2 || ren_addr_q[0] !== 8'd1 || ren_cyc_q[0] <= t_ill + 2) begin
            errors++;
            $display("FAIL illegal_noaccess: reads=%0d first_addr=%0d first_cyc=%0d, required 2 reads from 1 after %0d",
                     ren_cyc_q.size(), (ren_addr_q.size() > 0) ? ren_addr_q[0] : 8'd0,
                     (ren_cyc_q.size() > 0) ? ren_cyc_q[0] : -1, t_ill + 2);
        end
        if (obs_q.size() > 0 && ren_cyc_q.size() > 0) begin
            checks++;
            if (obs_q[0].cyc - ren_cyc_q[0] !== 4) begin
                errors++;
                $display("FAIL illegal_add_timing: wb-rd1=%0d, required 4", obs_q[0].cyc - ren_cyc_q[0]);
            end
        end
        check_writes(1);
    endtask

    task automatic test_reset_exec();
        int t;
        int guard = 0;
        push_cmd(2'd0, 8'd1, 8'd2, 8'd30, 1'b0);
        t = hs_cyc;
        push_cmd(2'd0, 8'd1, 8'd2, 8'd31, 1'b0);
        push_cmd(2'd0, 8'd1, 8'd2, 8'd32, 1'b0);
        while (cyc < t + 5 && guard < 20) begin
            step();
            guard++;
        end
        i_rst = 1'b1;
        step();
        checks++;
        if (o_mem_wen !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b0 || o_arr_in1 !== '0) begin
            errors++;
            $display("FAIL rst_exec_state: wen=%0b busy=%0b ready=%0b in1=%h, required 0 0 0 0",
                     o_mem_wen, o_busy, o_cmd_ready, o_arr_in1);
        end
        i_rst = 1'b0;
        step();
        checks++;
        if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_exec_release: ready=%0b busy=%0b, required 1 0", o_cmd_ready, o_busy);
        end
        for (int i = 0; i < 30; i++) step();
        checks++;
        if (obs_q.size() !== 0 || stray_done !== 0) begin
            errors++;
            $display("FAIL rst_exec_discard: writes=%0d stray_done=%0d, required 0 0", obs_q.size(), stray_done);
        end
        $display("reset during exec: writes=%0d busy=%0b", obs_q.size(), o_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_matmul();
        test_back_to_back();
        test_illegal();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
